// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: op codes and arbiter state encoding shared by the scoreboard arbiter
package scoreboard_pkg;
  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_INC   = 2'd1,
    OP_DEC   = 2'd2,
    OP_ERASE = 2'd3
  } op_e;
  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_ISSUE      = 2'd1,
    ARB_ERASE_LOCK = 2'd2,
    ARB_GAP        = 2'd3
  } arb_state_e;
endpackage

// File: rtl/scoreboard_arbiter_rr_pick.sv
// rr_pick: first set request at or after the round-robin pointer, wrapping modulo N_REQ
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [IW-1:0]    grant_o,
  output logic             any_o
);
  logic [IW-1:0] idx;
  // scan from the farthest offset down so the nearest requester wins
  always_comb begin
    grant_o = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_i) + k) % N_REQ);
      if (req_i[idx]) grant_o = idx;
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/scoreboard_arbiter.sv
// scoreboard_arbiter: round-robin sharing of one inc/dec/erase scoreboard port between consoles
module scoreboard_arbiter
  import scoreboard_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ERASE_HOLD = 5,
  parameter int GAP_CYC    = 2,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [2*N_REQ-1:0] op_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic               err_o,
  output logic               inc_o,
  output logic               dec_o,
  output logic               erase_o,
  output logic               busy_o,
  output logic [IW-1:0]      owner_o
);
  localparam int HW = $clog2(ERASE_HOLD + 1);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam arb_state_e EXIT_ST = (GAP_CYC > 0) ? ARB_GAP : ARB_IDLE;
  arb_state_e state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, owner_q, owner_d, grant, owner_nxt;
  op_e op_q, op_d, grant_op, own_op;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic any_req, valid, last_hold, done;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i  (req_i),
    .ptr_i  (rr_q),
    .grant_o(grant),
    .any_o  (any_req)
  );
  assign grant_op  = op_e'(op_i[2*grant +: 2]);
  assign own_op    = op_e'(op_i[2*owner_q +: 2]);
  assign valid     = req_i[owner_q] && own_op == OP_ERASE;
  assign last_hold = hold_q == HW'(ERASE_HOLD - 1);
  assign owner_nxt = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
  assign ack_o     = done ? (N_REQ'(1) << owner_q) : '0;
  assign busy_o    = state_q != ARB_IDLE;
  assign owner_o   = busy_o ? owner_q : '0;
  // next state and Mealy pulse decode; any completed or aborted op funnels through done
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    op_d    = op_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    done    = 1'b0;
    err_o   = 1'b0;
    inc_o   = 1'b0;
    dec_o   = 1'b0;
    erase_o = 1'b0;
    case (state_q)
      ARB_IDLE: if (any_req) begin
        owner_d = grant;
        op_d    = grant_op;
        hold_d  = '0;
        state_d = (grant_op == OP_ERASE) ? ARB_ERASE_LOCK : ARB_ISSUE;
      end
      ARB_ISSUE: begin
        done  = 1'b1;
        inc_o = op_q == OP_INC;
        dec_o = op_q == OP_DEC;
      end
      ARB_ERASE_LOCK: begin
        done    = !valid || last_hold;
        err_o   = !valid;
        erase_o = valid && last_hold;
        hold_d  = hold_q + HW'(1);
      end
      default: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP_CYC - 1)) state_d = ARB_IDLE;
      end
    endcase
    if (done) begin
      rr_d    = owner_nxt;
      state_d = EXIT_ST;
      gap_d   = '0;
    end
  end
  // state and counter registers, cleared asynchronously so a reset drops any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      op_q    <= OP_NOP;
      hold_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end
endmodule
